// File: rtl/frequency_counter_mc_pkg.sv
// -----------------------------------------------------------------------------
// freq_counter_pkg
// Shared types and constants for the multi-channel frequency counter.
//   bcd_digit_t  : one 4-bit BCD digit
//   fsm_state_t  : gate sequencer states (ARM, COUNT)
//   SEG_TABLE    : active-high 7-segment patterns for 0..9 (bit0=a .. bit6=g)
//   SEG_DASH     : "-" pattern shown for an overflowed channel
//   SEG_BLANK    : all segments off (non-decimal nibble)
//   seg_encode() : BCD digit -> segment pattern
// -----------------------------------------------------------------------------
package freq_counter_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic {
      ARM   = 1'b0,
      COUNT = 1'b1
   } fsm_state_t;

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Entry n holds the pattern for digit n.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] seg_encode(input bcd_digit_t d);
      logic [6:0] seg;
      if (d > 4'd9) begin
         seg = SEG_BLANK;
      end else begin
         seg = SEG_TABLE[d];
      end
      return seg;
   endfunction

endpackage

// File: rtl/frequency_counter_mc_bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// Saturating DIGITS-digit BCD event counter with a sticky overflow bit.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clear_i           : zero the count and overflow (wins over inc_i)
//   inc_i             : count one event
//   count_next_o      : count value after this cycle's update
//   overflow_next_o   : overflow bit after this cycle's update
// The outputs expose the next-state view so the owner can capture a result
// that already includes an event arriving in the capture cycle.
// -----------------------------------------------------------------------------
module bcd_counter
   import freq_counter_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                inc_i,
   output logic [DIGITS*4-1:0] count_next_o,
   output logic                overflow_next_o
);

   logic [DIGITS*4-1:0] count_q;
   logic [DIGITS*4-1:0] count_d;
   logic                overflow_q;
   logic                overflow_d;
   logic [DIGITS-1:0]   nine;
   logic [DIGITS-1:0]   carry;
   logic                saturated;

   // Once every digit is 9 the counter stops; further events only mark overflow.
   assign saturated = &nine;
   assign carry[0]  = inc_i & ~saturated;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_digit_t cur;
         assign cur      = count_q[gi*4 +: 4];
         assign nine[gi] = (cur == 4'd9);
         assign count_d[gi*4 +: 4] = clear_i  ? 4'd0 :
                                     carry[gi] ? (nine[gi] ? 4'd0 : cur + 4'd1) :
                                     cur;
         // Ripple carry into the next digit when this one wraps 9 -> 0.
         if (gi < DIGITS - 1) begin : g_carry
            assign carry[gi+1] = carry[gi] & nine[gi];
         end
      end
   endgenerate

   assign overflow_d = clear_i ? 1'b0 : (overflow_q | (inc_i & saturated));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign count_next_o    = count_d;
   assign overflow_next_o = overflow_d;

endmodule

// File: rtl/frequency_counter_mc.sv
// -----------------------------------------------------------------------------
// frequency_counter_mc
// Counts rising edges on CHANNELS asynchronous inputs over a programmable gate
// of clk cycles, latches each count as DIGITS BCD digits and shows the selected
// channel on a multiplexed 7-segment display.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   signal        : inputs to measure (asynchronous)
//   period_load   : strobe; load period (values < 2 ignored), restarts the gate
//   period        : new gate length in clk cycles
//   channel_sel   : channel shown on the display (out of range -> channel 0)
//   segments      : active-high segments, bit0=a .. bit6=g
//   digit         : one-hot digit enable, bit0 = least significant digit
//   result_valid  : one-cycle pulse when new results are latched
//   overflow      : per-channel overflow flag of the latched result
// -----------------------------------------------------------------------------
module frequency_counter_mc
   import freq_counter_pkg::*;
#(
   parameter int  CHANNELS       = 2,
   parameter int  DIGITS         = 2,
   parameter int  PERIOD_W       = 16,
   parameter int  DEFAULT_PERIOD = 1000,
   parameter int  MUX_DIV_W      = 8,
   localparam int SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] signal,
   input  logic                period_load,
   input  logic [PERIOD_W-1:0] period,
   input  logic [SEL_W-1:0]    channel_sel,
   output logic [6:0]          segments,
   output logic [DIGITS-1:0]   digit,
   output logic                result_valid,
   output logic [CHANNELS-1:0] overflow
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

   // ---------------- input synchronisers and edge detect ----------------
   logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
   logic [CHANNELS-1:0] edge_det;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= signal;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign edge_det = sync2_q & ~sync3_q;

   // ---------------- gate sequencer ----------------
   fsm_state_t          state_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] gate_q;
   logic                result_valid_q;
   logic                load_ok;
   logic                gate_last;
   logic                latch;

   assign load_ok   = period_load && (period >= PERIOD_W'(2));
   assign gate_last = (state_q == COUNT) && (gate_q == period_q - PERIOD_W'(1));
   // A valid load in the final COUNT cycle discards the partial gate.
   assign latch     = gate_last & ~load_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ARM;
         period_q       <= PERIOD_W'(DEFAULT_PERIOD);
         gate_q         <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (load_ok) begin
            period_q <= period;
            state_q  <= ARM;
         end else begin
            case (state_q)
               ARM: begin
                  gate_q  <= '0;
                  state_q <= COUNT;
               end
               COUNT: begin
                  gate_q <= gate_q + PERIOD_W'(1);
                  if (gate_last) begin
                     result_valid_q <= 1'b1;
                     state_q        <= ARM;
                  end
               end
               default: state_q <= ARM;
            endcase
         end
      end
   end

   // ---------------- per-channel counters and results ----------------
   logic                cnt_clear;
   logic [CHANNELS-1:0] cnt_inc;
   logic [DIGITS*4-1:0] cnt_next [CHANNELS];
   logic [CHANNELS-1:0] ovf_next;
   logic [DIGITS*4-1:0] result_q [CHANNELS];
   logic [CHANNELS-1:0] overflow_q;

   // Edges seen during ARM are dropped because clear dominates.
   assign cnt_clear = (state_q == ARM);
   assign cnt_inc   = edge_det & {CHANNELS{state_q == COUNT}};

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         bcd_counter #(
            .DIGITS (DIGITS)
         ) u_cnt (
            .clk             (clk),
            .reset           (reset),
            .clear_i         (cnt_clear),
            .inc_i           (cnt_inc[gi]),
            .count_next_o    (cnt_next[gi]),
            .overflow_next_o (ovf_next[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            result_q[c] <= '0;
         end
         overflow_q <= '0;
      end else if (latch) begin
         for (int c = 0; c < CHANNELS; c++) begin
            result_q[c] <= cnt_next[c];
         end
         overflow_q <= ovf_next;
      end
   end

   // ---------------- display multiplexer ----------------
   logic [MUX_DIV_W-1:0] div_q;
   logic [IDX_W-1:0]     idx_q;
   logic [SEL_W-1:0]     sel_eff;
   logic [DIGITS*4-1:0]  sel_result;
   bcd_digit_t           cur_digit;
   logic [DIGITS-1:0]    digit_d;
   logic [6:0]           seg_d;
   logic [6:0]           seg_q;
   logic [DIGITS-1:0]    digit_q;

   assign sel_eff    = ({1'b0, channel_sel} < CH_LIMIT) ? channel_sel : '0;
   assign sel_result = result_q[sel_eff];

   always_comb begin
      cur_digit = '0;
      digit_d   = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (idx_q == IDX_W'(d)) begin
            cur_digit  = sel_result[d*4 +: 4];
            digit_d[d] = 1'b1;
         end
      end
      seg_d = overflow_q[sel_eff] ? SEG_DASH : seg_encode(cur_digit);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_TABLE[0];
         digit_q <= DIGITS'(1);
      end else begin
         div_q <= div_q + MUX_DIV_W'(1);
         if (&div_q) begin
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end
         seg_q   <= seg_d;
         digit_q <= digit_d;
      end
   end

   assign segments     = seg_q;
   assign digit        = digit_q;
   assign result_valid = result_valid_q;
   assign overflow     = overflow_q;

endmodule
